mem_lsu: RTL

MEM_LSU -- requirements
Module: mem_lsu

---
 rtl/mem_lsu.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/mem_lsu.sv
// mem_lsu: load/store unit between the EX/MEM stage and a synchronous-read
// data RAM. Word stores complete in one cycle. Loads and byte/half stores take
// one stall cycle. During that cycle the RAM is read, and in the next cycle
// the load result is returned or the merged word is written back.
// Optional feature: define MEM_LSU_STALL_CNT_EN to build a 32-bit counter of
// stalled cycles on stall_cnt. Without it, stall_cnt is tied to zero.
module mem_lsu #(
  parameter int ADDR_W = 10
) (
  input  logic              cpu_clk,
  input  logic              cpu_rstn,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              stall,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              misalign_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic [31:0]       stall_cnt
);

  typedef enum logic [1:0] {IDLE, LD_WAIT, ST_MERGE} state_t;

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_addr;
  logic [1:0]        r_off;
  logic [1:0]        r_size;
  logic              r_unsigned;
  logic [15:0]       r_wdata;

  logic              w_is_word;
  logic              w_is_half;
  logic              w_misalign;
  logic [ADDR_W-1:0] w_req_word;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [31:0]       w_load;
  logic [31:0]       w_merge;
  logic              w_unused;

  // Size 11 is handled as a word access.
  assign w_is_word  = req_size[1];
  assign w_is_half  = (req_size == 2'b01);
  assign w_misalign = (w_is_half & req_addr[0]) | (w_is_word & (|req_addr[1:0]));
  assign w_req_word = req_addr[ADDR_W+1:2];
  // The byte address bits above the RAM's reach are not used.
  assign w_unused   = ^req_addr[31:ADDR_W+2];

  // State register. Request fields are captured on every request seen in
  // IDLE, so they are valid for the following LD_WAIT or ST_MERGE cycle.
  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the values from before the edge and results do not depend on
  // process evaluation order.
  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) begin
      r_state    <= IDLE;
      r_addr     <= '0;
      r_off      <= 2'b00;
      r_size     <= 2'b00;
      r_unsigned <= 1'b0;
      r_wdata    <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && req_valid) begin
        r_addr     <= w_req_word;
        r_off      <= req_addr[1:0];
        r_size     <= req_size;
        r_unsigned <= req_unsigned;
        r_wdata    <= req_wdata[15:0];
      end
    end
  end

  // Lane selection and extension for loads, and the read-modify-write merge
  // for byte/half stores, both taken from the word the RAM has just returned.
  always_comb begin
    w_byte  = mem_rdata[{r_off, 3'b000} +: 8];
    w_half  = r_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    w_merge = mem_rdata;
    case (r_size)
      2'b00: begin
        w_load = {{24{~r_unsigned & w_byte[7]}}, w_byte};
        w_merge[{r_off, 3'b000} +: 8] = r_wdata[7:0];
      end
      2'b01: begin
        w_load = {{16{~r_unsigned & w_half[15]}}, w_half};
        w_merge[{r_off[1], 4'b0000} +: 16] = r_wdata;
      end
      default: w_load = mem_rdata;
    endcase
  end

  // Next state and outputs. Reset low forces every output to zero at once,
  // without waiting for a clock edge.
  // NOTE: every output gets a default before any branch, so no path through
  // this block leaves a value unassigned and no latch is inferred.
  always_comb begin
    w_next       = r_state;
    stall        = 1'b0;
    rsp_valid    = 1'b0;
    rsp_rdata    = '0;
    misalign_err = 1'b0;
    mem_addr     = '0;
    mem_we       = 1'b0;
    mem_wdata    = '0;
    if (cpu_rstn) begin
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            if (w_misalign) begin
              misalign_err = 1'b1;
            end else begin
              mem_addr = w_req_word;
              if (req_we && w_is_word) begin
                mem_we    = 1'b1;
                mem_wdata = req_wdata;
              end else begin
                stall  = 1'b1;
                w_next = req_we ? ST_MERGE : LD_WAIT;
              end
            end
          end
        end
        // The request is still presented on the inputs here. It is ignored.
        LD_WAIT: begin
          rsp_valid = 1'b1;
          rsp_rdata = w_load;
          mem_addr  = r_addr;
          w_next    = IDLE;
        end
        ST_MERGE: begin
          mem_we    = 1'b1;
          mem_wdata = w_merge;
          mem_addr  = r_addr;
          w_next    = IDLE;
        end
        default: w_next = IDLE;
      endcase
    end
  end

`ifdef MEM_LSU_STALL_CNT_EN
  logic [31:0] r_stall_cnt;

  // Count every stalled cycle. The counter wraps modulo 2^32.
  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) r_stall_cnt <= '0;
    else if (stall) r_stall_cnt <= r_stall_cnt + 32'd1;
  end

  assign stall_cnt = r_stall_cnt;
`else
  assign stall_cnt = '0;
`endif

endmodule
